// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one register command in, one AXI4-Lite write or read out, one response back.
// Optional watchdog abort is built only when AXIL_MST_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | cmd_ready high, waiting for a command
// WR_REQ   | awvalid/wvalid outstanding, each drops on its own handshake
// WR_RESP  | bready high, waiting for bvalid
// RD_REQ   | arvalid high, waiting for arready
// RD_RESP  | rready high, waiting for rvalid
// DONE     | rsp_valid high with a stable payload, waiting for rsp_ready
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP, ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;

  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;
  logic                          rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept;
  logic xfer_active;
  logic wd_expired;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign b_hs   = bready_q & m_axi_bvalid;
  assign ar_hs  = arvalid_q & m_axi_arready;
  assign r_hs   = rready_q & m_axi_rvalid;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign xfer_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                       (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

`ifdef AXIL_MST_TIMEOUT_EN
  logic [15:0] wd_cnt_q;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wd_cnt_q <= '0;
    end else if (cmd_accept) begin
      wd_cnt_q <= '0;
    end else if (xfer_active && (wd_cnt_q != 16'hFFFF)) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end

  // Expiry is evaluated in the last allowed cycle so the abort lands exactly at the limit.
  assign wd_expired = (wd_cnt_q >= 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      araddr_q <= '0;
    end else if (cmd_accept) begin
      if (cmd_wr) begin
        awaddr_q <= cmd_addr;
        wdata_q  <= cmd_wdata;
        wstrb_q  <= cmd_wstrb;
      end else begin
        araddr_q <= cmd_addr;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_accept    = 1'b1;
          rsp_timeout_d = 1'b0;
          if (cmd_wr) begin
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          state_d     = ST_DONE;
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
        end
      end
      ST_RD_REQ: begin
        if (ar_hs) begin
          state_d   = ST_RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (r_hs) begin
          state_d     = ST_DONE;
          rready_d    = 1'b0;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A handshake in the expiry cycle takes priority; the abort retries next cycle if still stuck.
    if (wd_expired && xfer_active && !any_hs) begin
      state_d       = ST_DONE;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed vector table, reset/timeout sequences and
// randomized transactions against a transaction-level model with a scripted AXI slave.
module tb_axi_lite_master;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0]    slv_resp;
    logic [DW-1:0] slv_rdata;
    int            bp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    bit            exp_to;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: writes report BRESP with zero data, reads report RDATA/RRESP.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_rdata = v.wr ? '0 : v.slv_rdata;
    r.exp_resp  = v.slv_resp;
    r.exp_to    = 1'b0;
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0, got = 0, first = 1;
    bit both_prev, ar_prev;
    int aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = 0, r_cnt = 0, cyc = 0;
    int aw_beats = 0, w_beats = 0, ar_beats = 0, ar_hi = 0;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = 4'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_wr = 1'($urandom);
    while (cyc < 300) begin
      if (b_done || r_done) begin
        chk("rsp_next_cycle", 64'(rsp_valid), 64'(1));
        got = 1;
        break;
      end
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (first) begin
        chk("busy_active", 64'(busy), 64'(1));
        chk("cmd_ready_low", 64'(cmd_ready), 64'(0));
        if (v.wr) chk("aw_w_valid_next", 64'({awvalid, wvalid}), 64'(2'b11));
        else      chk("arvalid_next", 64'(arvalid), 64'(1));
        first = 0;
      end
      both_prev = aw_done && w_done;
      ar_prev   = ar_done;
      if (v.wr) begin
        if (!aw_done) begin
          chk("awvalid_held", 64'(awvalid), 64'(1));
          chk("awaddr_hold", 64'(awaddr), 64'(v.addr));
          awready = (aw_seen >= v.aw_wait);
          aw_seen++;
          if (awvalid && awready) begin aw_beats++; aw_done = 1; end
        end else begin
          chk("aw_no_dup", 64'(awvalid), 64'(0));
          awready = 1'b0;
        end
        if (!w_done) begin
          chk("wvalid_held", 64'(wvalid), 64'(1));
          chk("wdata_hold", 64'(wdata), 64'(v.wdata));
          chk("wstrb_hold", 64'(wstrb), 64'(v.wstrb));
          wready = (w_seen >= v.w_wait);
          w_seen++;
          if (wvalid && wready) begin w_beats++; w_done = 1; end
        end else begin
          chk("w_no_dup", 64'(wvalid), 64'(0));
          wready = 1'b0;
        end
        if (both_prev) begin
          if (b_cnt == 0) chk("bready_on_entry", 64'(bready), 64'(1));
          bvalid = (b_cnt >= v.b_wait);
          bresp  = v.slv_resp;
          b_cnt++;
          if (bvalid && bready) b_done = 1;
        end else begin
          chk("bready_not_early", 64'(bready), 64'(0));
          bvalid = 1'b0;
        end
        chk("ar_quiet_on_write", 64'({arvalid, rready}), 64'(0));
      end else begin
        if (!ar_done) begin
          chk("arvalid_held", 64'(arvalid), 64'(1));
          chk("araddr_hold", 64'(araddr), 64'(v.addr));
          if (arvalid) ar_hi++;
          arready = (ar_seen >= v.ar_wait);
          ar_seen++;
          if (arvalid && arready) begin ar_beats++; ar_done = 1; end
        end else begin
          chk("ar_no_dup", 64'(arvalid), 64'(0));
          arready = 1'b0;
        end
        if (ar_prev) begin
          if (r_cnt == 0) chk("rready_on_entry", 64'(rready), 64'(1));
          rvalid = (r_cnt >= v.r_wait);
          rdata  = rvalid ? v.slv_rdata : $urandom;
          rresp  = v.slv_resp;
          r_cnt++;
          if (rvalid && rready) r_done = 1;
        end else begin
          chk("rready_not_early", 64'(rready), 64'(0));
          rvalid = 1'b0;
        end
        chk("aw_quiet_on_read", 64'({awvalid, wvalid, bready}), 64'(0));
      end
      @(negedge clk);
      cyc++;
    end
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    chk("rsp_seen", 64'(got), 64'(1));
    chk("axi_quiet_in_done", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    chk("rsp_resp", 64'(rsp_resp), 64'(v.exp_resp));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(v.exp_to));
    if (v.exp_to) begin
      chk("to_arvalid_cycles", 64'(ar_hi), 64'(TO));
      chk("to_no_ar_beat", 64'(ar_beats), 64'(0));
    end else if (v.wr) begin
      chk("aw_beats", 64'(aw_beats), 64'(1));
      chk("w_beats", 64'(w_beats), 64'(1));
    end else begin
      chk("ar_beats", 64'(ar_beats), 64'(1));
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < v.bp; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'($urandom); cmd_addr = 4'($urandom);
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rdata_stable", 64'(rsp_rdata), 64'(v.exp_rdata));
      chk("bp_resp_stable", 64'(rsp_resp), 64'(v.exp_resp));
      chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("bp_cmd_ignored", 64'({awvalid, wvalid, arvalid}), 64'(0));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_back", 64'(cmd_ready), 64'(1));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    //          wr addr   wdata          strb   aw w  b  ar r  resp   slv_rdata      bp  exp_rdata      exp_resp to
    tbl[0] = '{1, 4'h0, 32'h0000_0003, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,          0,  32'h0,          2'b00, 0};
    tbl[1] = '{1, 4'h8, 32'hA5A5_0001, 4'h3, 3, 0, 1, 0, 0, 2'b00, 32'h0,          0,  32'h0,          2'b00, 0};
    tbl[2] = '{1, 4'hC, 32'h1234_5678, 4'hF, 0, 2, 0, 0, 0, 2'b10, 32'h0,          0,  32'h0,          2'b10, 0};
    tbl[3] = '{0, 4'h4, 32'h0,         4'h0, 0, 0, 0, 0, 5, 2'b00, 32'h0000_0002, 0,  32'h0000_0002, 2'b00, 0};
    tbl[4] = '{0, 4'h4, 32'h0,         4'h0, 0, 0, 0, 3, 0, 2'b11, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 2'b11, 0};
    tbl[5] = '{1, 4'h0, 32'h0000_0001, 4'h1, 1, 1, 2, 0, 0, 2'b01, 32'h0,          10, 32'h0,          2'b01, 0};
    tbl[6] = '{0, 4'h8, 32'h0,         4'h0, 0, 0, 0, 1, 1, 2'b00, 32'h8000_0000, 10, 32'h8000_0000, 2'b00, 0};

    rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_valids_readies", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    chk("rst_rsp_flags", 64'({rsp_valid, rsp_timeout, busy}), 64'(0));
    chk("rst_buses", 64'({awaddr, araddr, wstrb}), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_rsp_payload", 64'({rsp_rdata, rsp_resp}), 64'(0));
    chk("prot_tied", 64'({awprot, arprot}), 64'(0));

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Reset while waiting in WR_RESP: everything returns idle, no response appears.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("rst_seq_bready", 64'(bready), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_seq_quiet", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    chk("rst_seq_busy", 64'(busy), 64'(0));
    chk("rst_seq_cmd_ready", 64'(cmd_ready), 64'(1));
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_seq_no_rsp", 64'(rsp_valid), 64'(0));
    end
    run_txn(tbl[0]);
    run_txn(tbl[3]);

    for (int i = 0; i < 40; i++) begin
      rv.wr = 1'($urandom); rv.addr = 4'($urandom); rv.wdata = $urandom; rv.wstrb = 4'($urandom);
      rv.aw_wait = int'($urandom_range(0, 3)); rv.w_wait = int'($urandom_range(0, 3));
      rv.b_wait = int'($urandom_range(0, 3)); rv.ar_wait = int'($urandom_range(0, 3));
      rv.r_wait = int'($urandom_range(0, 3)); rv.slv_resp = 2'($urandom);
      rv.slv_rdata = $urandom; rv.bp = int'($urandom_range(0, 2));
      rv = model(rv);
      run_txn(rv);
    end

`ifdef AXIL_MST_TIMEOUT_EN
    rv = '{0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 32'h1234, 0, 32'h0, 2'b10, 1};
    run_txn(rv);
    run_txn(tbl[3]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
